// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared types and constants for the I2C register target.
// Holds the FSM state encoding, ACK/NACK bus levels, bit-counter sizing
// and the register-pointer increment helper.
package i2c_target_pkg;

  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned STATE_W   = 4;
  localparam int unsigned BYTE_W    = 8;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_ADDR      = 4'd1;
  localparam state_t ST_ADDR_ACK  = 4'd2;
  localparam state_t ST_PTR       = 4'd3;
  localparam state_t ST_PTR_ACK   = 4'd4;
  localparam state_t ST_WDATA     = 4'd5;
  localparam state_t ST_WDATA_ACK = 4'd6;
  localparam state_t ST_RDATA     = 4'd7;
  localparam state_t ST_RDATA_ACK = 4'd8;
  localparam state_t ST_IGNORE    = 4'd9;

  // Bus level during the acknowledge bit
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] BIT_FULL = BIT_CNT_W'(8);

  // Register pointer advance, wraps 0xFF -> 0x00
  function automatic logic [BYTE_W-1:0] ptr_next(input logic [BYTE_W-1:0] ptr);
    return BYTE_W'(ptr + BYTE_W'(1));
  endfunction

endpackage

// File: rtl/i2c_target_sync.sv
// i2c_target_sync: SCL/SDA synchronizer plus bus event detector.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   scl_i, sda_i             raw pad inputs
//   scl_s, sda_s             synchronized levels (registered)
//   scl_rise_c, scl_fall_c   one-clk SCL edge pulses (combinational)
//   start_c, stop_c          one-clk START/STOP pulses (combinational)
module i2c_target_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;

  // Idle bus level is high, so everything resets to 1
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise_c = scl_s & ~scl_prev;
  assign scl_fall_c = ~scl_s & scl_prev;
  // SDA edges only count as START/STOP while SCL is stable high
  assign start_c    = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_c     = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target with an 8-bit register pointer and a simple
// register-file access port.
// Ports:
//   clk_i, rst_ni     clock (>= 16x SCL), synchronous active-low reset
//   scl_i, sda_i      bus pad inputs
//   sda_o, sda_t      open-drain SDA: value is always 0, sda_t=1 releases
//   reg_addr_o        register pointer
//   reg_wdata_o       write data, valid with reg_wen_o
//   reg_wen_o         one-clk write strobe
//   reg_ren_o         one-clk read-fetch strobe for reg_addr_o
//   reg_rdata_i       read data, sampled one clk after reg_ren_o
//   busy_o            addressed transaction in progress
// Build option: define I2C_TARGET_AUTOINC_EN to advance the pointer after
// every written byte and every ACKed read byte (burst access).
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  DADDR       = 7'h20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_t,
  output logic [BYTE_W-1:0] reg_addr_o,
  output logic [BYTE_W-1:0] reg_wdata_o,
  output logic              reg_wen_o,
  output logic              reg_ren_o,
  input  logic [BYTE_W-1:0] reg_rdata_i,
  output logic              busy_o
);

  logic scl_s, sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_target_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_s      (scl_s),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      shreg_q, shreg_d;
  logic                   rw_q, rw_d;
  logic                   ren_dly_q;
  logic                   sda_t_d, busy_d, wen_d, ren_d;
  logic [BYTE_W-1:0]      addr_d, wdata_d;
  logic [BYTE_W-1:0]      rx_byte;

  assign sda_o = 1'b0;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rw_q        <= 1'b0;
      ren_dly_q   <= 1'b0;
      sda_t       <= 1'b1;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wen_o   <= 1'b0;
      reg_ren_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      ren_dly_q   <= reg_ren_o;
      sda_t       <= sda_t_d;
      reg_addr_o  <= addr_d;
      reg_wdata_o <= wdata_d;
      reg_wen_o   <= wen_d;
      reg_ren_o   <= ren_d;
      busy_o      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rw_d      = rw_q;
    sda_t_d   = sda_t;
    addr_d    = reg_addr_o;
    wdata_d   = reg_wdata_o;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    busy_d    = busy_o;
    rx_byte   = {shreg_q[BYTE_W-2:0], sda_s};

    // Fetched read data lands here; drive its MSB straight away only when
    // SCL is already low, otherwise wait for the next falling edge.
    if (ren_dly_q) begin
      shreg_d = reg_rdata_i;
      if (!scl_s) sda_t_d = reg_rdata_i[BYTE_W-1];
    end

`ifdef I2C_TARGET_AUTOINC_EN
    // Advance after the write strobe has been seen with the old pointer
    if (reg_wen_o) addr_d = ptr_next(reg_addr_o);
`endif

    if (start_c) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
      busy_d    = 1'b0;
    end else if (stop_c) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise_c) begin
            shreg_d   = rx_byte;
            bit_cnt_d = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              rw_d      = sda_s;
              if (shreg_q[6:0] == DADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_PTR, ST_WDATA: begin
          if (scl_rise_c) begin
            shreg_d   = rx_byte;
            bit_cnt_d = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              if (state_q == ST_PTR) begin
                addr_d  = rx_byte;
                state_d = ST_PTR_ACK;
              end else begin
                wdata_d = rx_byte;
                wen_d   = 1'b1;
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end

        // First falling edge pulls SDA low, second one ends the ACK bit
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_c) begin
            if (sda_t) begin
              sda_t_d = ACK;
            end else begin
              sda_t_d   = 1'b1;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK) begin
                if (rw_q) begin
                  ren_d   = 1'b1;
                  state_d = ST_RDATA;
                end else begin
                  state_d = ST_PTR;
                end
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise_c && bit_cnt_q != BIT_FULL) begin
            bit_cnt_d = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
          end
          if (scl_fall_c) begin
            if (bit_cnt_q == '0) begin
              sda_t_d = shreg_q[BYTE_W-1];
            end else if (bit_cnt_q == BIT_FULL) begin
              sda_t_d = 1'b1;
              state_d = ST_RDATA_ACK;
            end else begin
              shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
              sda_t_d = shreg_q[BYTE_W-2];
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise_c) begin
            bit_cnt_d = '0;
            if (sda_s == NACK) begin
              state_d = ST_IGNORE;
            end else begin
`ifdef I2C_TARGET_AUTOINC_EN
              addr_d = ptr_next(reg_addr_o);
`endif
              ren_d   = 1'b1;
              state_d = ST_RDATA;
            end
          end
        end

        ST_IDLE, ST_IGNORE: begin
          sda_t_d = 1'b1;
        end

        default: begin
          state_d = ST_IDLE;
          sda_t_d = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target. A bit-banged initiator
// drives the bus; a synchronous register-file model answers read fetches.
// Expected strobes are queued as stimulus is issued and checked as the DUT
// produces them. Honors I2C_TARGET_AUTOINC_EN for pointer expectations.
module tb_i2c_target;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       scl_m, sda_m, sda_bus;
  logic       sda_o, sda_t;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata;
  logic       reg_wen_o, reg_ren_o, busy_o;

  logic [7:0] mem [256];
  wr_t        exp_wen [$];
  logic [7:0] exp_ren [$];

  int errors = 0;
  int checks = 0;
  logic watch_rel = 1'b0;
  int   low_cnt = 0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of initiator and target
  assign sda_bus = sda_m & (sda_t ? 1'b1 : sda_o);

  i2c_target dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .sda_t       (sda_t),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wen_o   (reg_wen_o),
    .reg_ren_o   (reg_ren_o),
    .reg_rdata_i (reg_rdata),
    .busy_o      (busy_o)
  );

  // Synchronous register file: data valid the cycle after the fetch strobe
  always @(posedge clk) begin
    if (reg_ren_o) reg_rdata <= mem[reg_addr_o];
  end

  // Strobe scoreboard and SDA-release watcher
  always @(negedge clk) begin
    wr_t        e;
    logic [7:0] ea;
    if (rst_ni) begin
      if (reg_wen_o) begin
        checks++;
        assert (exp_wen.size() != 0) else begin
          errors++;
          $error("FAIL wen_unexpected: observed addr=%0h data=%0h, required no strobe", reg_addr_o, reg_wdata_o);
        end
        if (exp_wen.size() != 0) begin
          e = exp_wen.pop_front();
          checks++;
          assert ({reg_addr_o, reg_wdata_o} === e) else begin
            errors++;
            $error("FAIL wen_payload: observed addr=%0h data=%0h, required addr=%0h data=%0h", reg_addr_o, reg_wdata_o, e.addr, e.data);
          end
        end
      end
      if (reg_ren_o) begin
        checks++;
        assert (exp_ren.size() != 0) else begin
          errors++;
          $error("FAIL ren_unexpected: observed addr=%0h, required no strobe", reg_addr_o);
        end
        if (exp_ren.size() != 0) begin
          ea = exp_ren.pop_front();
          checks++;
          assert (reg_addr_o === ea) else begin
            errors++;
            $error("FAIL ren_addr: observed %0h, required %0h", reg_addr_o, ea);
          end
        end
      end
      if (reg_wen_o && reg_ren_o) begin
        checks++;
        assert (!(reg_wen_o && reg_ren_o)) else begin
          errors++;
          $error("FAIL wen_ren_overlap: observed both strobes, required at most one");
        end
      end
      if (watch_rel && sda_t !== 1'b1) low_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  // One SCL pulse: drive b, sample the bus mid-high
  task automatic clock_bit(input logic b, output logic seen);
    tick(Q);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(Q);
    seen = sda_bus; tick(Q);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic do_ack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clock_bit(~do_ack, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_t"}, 8'(sda_t), 8'h01);
    check({tag, "_sda_o"}, 8'(sda_o), 8'h00);
    check({tag, "_addr"},  reg_addr_o, 8'h00);
    check({tag, "_wdata"}, reg_wdata_o, 8'h00);
    check({tag, "_wen"},   8'(reg_wen_o), 8'h00);
    check({tag, "_ren"},   8'(reg_ren_o), 8'h00);
    check({tag, "_busy"},  8'(busy_o), 8'h00);
  endtask

  logic       ack;
  logic [7:0] rd;
  logic       dummy;
  bit         autoinc;

  initial begin
`ifdef I2C_TARGET_AUTOINC_EN
    autoinc = 1'b1;
`else
    autoinc = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h13] = 8'h5C;
    mem[8'h14] = 8'h3E;
    mem[8'h30] = 8'h5C;
    reg_rdata = 8'h00;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rst_ni = 1'b0;
    tick(5);
    check_reset_outputs("rst");
    rst_ni = 1'b1;
    tick(5);

    // Single register write
    exp_wen.push_back({8'h14, 8'hA5});
    i2c_start();
    write_byte(8'h40, ack); check("t1_addr_ack", 8'(ack), 8'h01);
    check("t1_busy_on", 8'(busy_o), 8'h01);
    write_byte(8'h14, ack); check("t1_ptr_ack", 8'(ack), 8'h01);
    write_byte(8'hA5, ack); check("t1_data_ack", 8'(ack), 8'h01);
    i2c_stop(); tick(5);
    check("t1_busy_off", 8'(busy_o), 8'h00);
    check("t1_ptr", reg_addr_o, autoinc ? 8'h15 : 8'h14);

    // Pointer write, repeated START, single read with NACK
    exp_ren.push_back(8'h13);
    i2c_start();
    write_byte(8'h40, ack); check("t2_addr_ack", 8'(ack), 8'h01);
    write_byte(8'h13, ack); check("t2_ptr_ack", 8'(ack), 8'h01);
    i2c_start();
    write_byte(8'h41, ack); check("t2_raddr_ack", 8'(ack), 8'h01);
    read_byte(1'b0, rd);    check("t2_rdata", rd, 8'h5C);
    low_cnt = 0; watch_rel = 1'b1; tick(30); watch_rel = 1'b0;
    check("t2_released_after_nack", 8'(low_cnt), 8'h00);
    // Two-byte read: ACK then NACK
    exp_ren.push_back(8'h13);
    exp_ren.push_back(autoinc ? 8'h14 : 8'h13);
    i2c_start();
    write_byte(8'h41, ack); check("t2b_raddr_ack", 8'(ack), 8'h01);
    read_byte(1'b1, rd);    check("t2b_rdata0", rd, 8'h5C);
    read_byte(1'b0, rd);    check("t2b_rdata1", rd, autoinc ? 8'h3E : 8'h5C);
    i2c_stop(); tick(5);
    check("t2_ptr", reg_addr_o, autoinc ? 8'h14 : 8'h13);

    // Foreign address: never acknowledged, no strobes
    low_cnt = 0; watch_rel = 1'b1;
    i2c_start();
    write_byte(8'h42, ack); check("t3_addr_nack", 8'(ack), 8'h00);
    write_byte(8'h00, ack); check("t3_b1_nack", 8'(ack), 8'h00);
    write_byte(8'h11, ack); check("t3_b2_nack", 8'(ack), 8'h00);
    check("t3_busy", 8'(busy_o), 8'h00);
    i2c_stop(); tick(5);
    watch_rel = 1'b0;
    check("t3_sda_never_low", 8'(low_cnt), 8'h00);
    check("t3_ptr", reg_addr_o, autoinc ? 8'h14 : 8'h13);

    // Two data bytes starting at 0xFF (pointer wrap with auto-increment)
    exp_wen.push_back({8'hFF, 8'h01});
    exp_wen.push_back({autoinc ? 8'h00 : 8'hFF, 8'h02});
    i2c_start();
    write_byte(8'h40, ack); check("t4_addr_ack", 8'(ack), 8'h01);
    write_byte(8'hFF, ack); check("t4_ptr_ack", 8'(ack), 8'h01);
    write_byte(8'h01, ack); check("t4_d0_ack", 8'(ack), 8'h01);
    write_byte(8'h02, ack); check("t4_d1_ack", 8'(ack), 8'h01);
    i2c_stop(); tick(5);
    check("t4_ptr", reg_addr_o, autoinc ? 8'h01 : 8'hFF);

    // STOP after a partial data byte: discarded, pointer kept
    i2c_start();
    write_byte(8'h40, ack); check("t5_addr_ack", 8'(ack), 8'h01);
    write_byte(8'h30, ack); check("t5_ptr_ack", 8'(ack), 8'h01);
    clock_bit(1'b1, dummy);
    clock_bit(1'b0, dummy);
    clock_bit(1'b1, dummy);
    clock_bit(1'b0, dummy);
    i2c_stop(); tick(5);
    check("t5_busy", 8'(busy_o), 8'h00);
    check("t5_sda_t", 8'(sda_t), 8'h01);
    check("t5_ptr", reg_addr_o, 8'h30);

    // Reset while the target drives a zero data bit
    exp_ren.push_back(8'h30);
    i2c_start();
    write_byte(8'h41, ack); check("t6_raddr_ack", 8'(ack), 8'h01);
    tick(8);
    check("t6_msb_driven_low", 8'(sda_t), 8'h00);
    rst_ni = 1'b0;
    tick(1);
    check_reset_outputs("t6");
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
    rst_ni = 1'b1; tick(Q);

    // Normal operation resumes after reset
    exp_wen.push_back({8'h07, 8'h99});
    i2c_start();
    write_byte(8'h40, ack); check("t7_addr_ack", 8'(ack), 8'h01);
    write_byte(8'h07, ack); check("t7_ptr_ack", 8'(ack), 8'h01);
    write_byte(8'h99, ack); check("t7_data_ack", 8'(ack), 8'h01);
    i2c_stop(); tick(5);
    check("t7_ptr", reg_addr_o, autoinc ? 8'h08 : 8'h07);

    check("wen_all_seen", 8'(exp_wen.size()), 8'h00);
    check("ren_all_seen", 8'(exp_ren.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
